// File: rtl/cla_pkg.sv
// Shared types and helpers for the sequential carry look-ahead adder.
package cla_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_CHUNK = 4;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Slice index needs at least one bit even when the word is a single slice.
  function automatic int unsigned idx_width(input int unsigned n);
    return (clog2(n) == 0) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational look-ahead cell: resolves one CHUNK-bit slice from g/p terms.
module cla_slice
  import cla_pkg::*;
#(
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] g,
  input  logic [CHUNK-1:0] p,
  input  logic             c_in,
  output logic [CHUNK-1:0] s,
  output logic             c_out,
  output logic             G_slice,
  output logic             P_slice,
  output logic             c_msb
);

  logic [CHUNK:0] c;
  logic           gacc;

  always_comb begin
    c    = '0;
    gacc = 1'b0;
    c[0] = c_in;
    for (int unsigned j = 0; j < CHUNK; j++) begin
      c[j+1] = g[j] | (p[j] & c[j]);
      gacc   = g[j] | (p[j] & gacc);
    end
  end

  assign s       = p ^ c[CHUNK-1:0];
  assign c_out   = c[CHUNK];
  assign G_slice = gacc;
  assign P_slice = &p;
  assign c_msb   = c[CHUNK-1];

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle CLA adder, one CHUNK slice per clock, valid/ready on both sides.
// Optional signed-overflow output enabled by defining CLA_SEQ_OVF_EN.
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             G_all,
  output logic             P_all
`ifdef CLA_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NS = WIDTH / CHUNK;
  localparam int unsigned IW = idx_width(NS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NS - 1);

  state_t state, state_nx;

  logic [WIDTH-1:0] a_q, b_q;
  logic             carry_q;
  logic [IW-1:0]    idx;
  logic [31:0]      base;
  logic             last;

  logic [WIDTH-1:0] g_w, p_w;
  logic [CHUNK-1:0] g_s, p_s, s_s;
  logic             c_out_s, G_s, P_s;

  assign g_w  = a_q & b_q;
  assign p_w  = a_q ^ b_q;
  assign base = 32'(idx) * CHUNK;
  assign last = (idx == LAST_IDX);
  assign g_s  = g_w[base +: CHUNK];
  assign p_s  = p_w[base +: CHUNK];

`ifdef CLA_SEQ_OVF_EN
  logic c_msb_s;
`endif

  cla_slice #(.CHUNK(CHUNK)) u_slice (
    .g       (g_s),
    .p       (p_s),
    .c_in    (carry_q),
    .s       (s_s),
    .c_out   (c_out_s),
    .G_slice (G_s),
    .P_slice (P_s),
`ifdef CLA_SEQ_OVF_EN
    .c_msb   (c_msb_s)
`else
    .c_msb   ()
`endif
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (in_valid) state_nx = ST_BUSY;
      ST_BUSY: if (last)     state_nx = ST_DONE;
      ST_DONE: if (out_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
  end

  // Index stops at the last slice and is only re-zeroed on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      sum     <= '0;
      co      <= 1'b0;
      G_all   <= 1'b0;
      P_all   <= 1'b1;
`ifdef CLA_SEQ_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= ci;
            idx     <= '0;
            G_all   <= 1'b0;
            P_all   <= 1'b1;
          end
        end
        ST_BUSY: begin
          sum[base +: CHUNK] <= s_s;
          carry_q            <= c_out_s;
          G_all              <= G_s | (P_s & G_all);
          P_all              <= P_all & P_s;
          if (last) begin
            co <= c_out_s;
`ifdef CLA_SEQ_OVF_EN
            ovf <= c_msb_s ^ c_out_s;
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Self-checking bench for cla_seq_adder: vector table, random model vectors, corner sequences.
module tb_cla_seq_adder;
  import cla_pkg::*;

  parameter int unsigned C = 4;
  localparam int unsigned W  = 16;
  localparam int unsigned NS = W / C;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] sum;
    logic        co;
    logic        g;
    logic        p;
    logic        ov;
  } vec_t;

  logic        clk, rst, in_valid, in_ready, ci, out_valid, out_ready, co, G_all, P_all;
  logic [15:0] a, b, sum;
`ifdef CLA_SEQ_OVF_EN
  logic        ovf;
`endif

  int   passed = 0;
  int   total  = 0;
  vec_t q[$];
  vec_t tbl[7];

  cla_seq_adder #(.WIDTH(W), .CHUNK(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .co        (co),
    .G_all     (G_all),
    .P_all     (P_all)
`ifdef CLA_SEQ_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t model(input logic [15:0] va, input logic [15:0] vb, input logic vci);
    vec_t v;
    logic [16:0] full, raw;
    full  = {1'b0, va} + {1'b0, vb} + 17'(vci);
    raw   = {1'b0, va} + {1'b0, vb};
    v.a   = va;
    v.b   = vb;
    v.ci  = vci;
    v.sum = full[15:0];
    v.co  = full[16];
    v.g   = raw[16];
    v.p   = &(va ^ vb);
    v.ov  = (va[15] == vb[15]) && (full[15] != va[15]);
    return v;
  endfunction

  task automatic start_add(input vec_t v, input bit track);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    a  = v.a;
    b  = v.b;
    ci = v.ci;
    if (track) q.push_back(v);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("in_ready_low_busy", in_ready, 0);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_result(input string tag);
    vec_t e;
    if (q.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 1, 0);
      return;
    end
    e = q.pop_front();
    chk({tag, "_sum"}, sum, e.sum);
    chk({tag, "_co"}, co, e.co);
    chk({tag, "_G_all"}, G_all, e.g);
    chk({tag, "_P_all"}, P_all, e.p);
`ifdef CLA_SEQ_OVF_EN
    chk({tag, "_ovf"}, ovf, e.ov);
`endif
  endtask

  // Full transaction with out_ready held high: expects a one-cycle out_valid pulse.
  task automatic do_add(input vec_t v, input string tag);
    int n;
    start_add(v, 1'b1);
    wait_done(n);
    chk({tag, "_latency"}, n, NS);
    check_result(tag);
    @(posedge clk); #1;
    chk({tag, "_valid_pulse"}, out_valid, 0);
    chk({tag, "_ready_back"}, in_ready, 1);
  endtask

  initial begin
    int n;
    vec_t v;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; ci = 1'b0;

    tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1};

    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_co", co, 0);
    chk("rst_G_all", G_all, 0);
    chk("rst_P_all", P_all, 1);
`ifdef CLA_SEQ_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) do_add(tbl[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < 8; i++) begin
      v = model(16'($urandom), 16'($urandom), 1'($urandom_range(1)));
      do_add(v, $sformatf("rnd%0d", i));
    end

    // Backpressure in DONE with ignored in_valid pulses.
    out_ready = 1'b0;
    start_add('{16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0}, 1'b1);
    wait_done(n);
    chk("bp_latency", n, NS);
    check_result("bp");
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = 16'h1111 * 16'(i + 1);
      b = 16'h0101;
      ci = 1'b1;
      @(posedge clk); #1;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_sum", sum, 16'h0000);
      chk("bp_hold_co", co, 1);
      chk("bp_hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);
    do_add(model(16'h0001, 16'h0002, 1'b0), "after_bp");

    // Asynchronous reset during the second BUSY cycle.
    start_add(tbl[0], 1'b0);
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    chk("midrst_sum", sum, 0);
    chk("midrst_co", co, 0);
    chk("midrst_G_all", G_all, 0);
    chk("midrst_P_all", P_all, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    #1 rst = 1'b0;
    do_add(tbl[4], "post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
